iob_ddr_in: RTL and testbench

Double-data-rate input capture and deserializer; the receive-side counterpart of the team's DDR output cell. It samples a WIDTH-bit pin bus on both edges of one clock and re-times each rising/falling beat pair into the rising-edge domain. It packs the beat stream into BEATS-beat words with a one-cycle valid strobe and supports beat-granular word alignment (bitslip). It sits between the pad ring and link-layer logic such as DDR data receivers and source-synchronous ADC front ends.

---
 rtl/iob_ddr_in.sv | 119 +++++++++++
 tb/tb_iob_ddr_in.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_ddr_in.sv
// DDR input capture: samples datain on both clock edges, re-times each beat pair
// into the rising-edge domain and packs the beat stream into BEATS-beat words with bitslip.
module iob_ddr_in #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned BEATS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     slip,
  input  logic [WIDTH-1:0]         datain,
  output logic [WIDTH-1:0]         pair_h,
  output logic [WIDTH-1:0]         pair_l,
  output logic                     pair_valid,
  output logic [WIDTH*BEATS-1:0]   dataout,
  output logic                     dataout_valid
);

  localparam int unsigned WORD_W = WIDTH * BEATS;
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  logic [WIDTH-1:0]  rise_q, rise_d;
  logic              en_q, en_d;
  logic [WIDTH-1:0]  fall_q, fall_d;
  logic [WIDTH-1:0]  pair_h_q, pair_h_d;
  logic [WIDTH-1:0]  pair_l_q, pair_l_d;
  logic              pair_valid_q, pair_valid_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              slip_pend_q, slip_pend_d;
  logic [WORD_W-1:0] dataout_q, dataout_d;
  logic              dataout_valid_q, dataout_valid_d;
  logic              drop_h;
  logic [WIDTH-1:0]  beat;

  // Capture and pair stages.
  always_comb begin
    rise_d       = datain;
    en_d         = en;
    fall_d       = datain;
    pair_h_d     = rise_q;
    pair_l_d     = fall_q;
    pair_valid_d = en_q;
  end

  // A live slip request counts on the same edge it is sampled.
  assign drop_h = pair_valid_q & (slip_pend_q | slip);

  // Word assembly: h then l; a word completed by h is snapshotted before l lands at beat 0.
  always_comb begin
    word_d          = word_q;
    cnt_d           = cnt_q;
    slip_pend_d     = slip_pend_q;
    dataout_d       = dataout_q;
    dataout_valid_d = 1'b0;
    beat            = '0;
    if (pair_valid_q) begin
      slip_pend_d = 1'b0;
    end else if (slip) begin
      slip_pend_d = 1'b1;
    end
    for (int b = 0; b < 2; b++) begin
      beat = (b == 0) ? pair_h_q : pair_l_q;
      if (pair_valid_q && !(b == 0 && drop_h)) begin
        word_d[int'(cnt_d) * WIDTH +: WIDTH] = beat;
        if (cnt_d == CNT_LAST) begin
          dataout_d       = word_d;
          dataout_valid_d = 1'b1;
          cnt_d           = '0;
        end else begin
          cnt_d = cnt_d + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q          <= '0;
      en_q            <= 1'b0;
      pair_h_q        <= '0;
      pair_l_q        <= '0;
      pair_valid_q    <= 1'b0;
      word_q          <= '0;
      cnt_q           <= '0;
      slip_pend_q     <= 1'b0;
      dataout_q       <= '0;
      dataout_valid_q <= 1'b0;
    end else begin
      rise_q          <= rise_d;
      en_q            <= en_d;
      pair_h_q        <= pair_h_d;
      pair_l_q        <= pair_l_d;
      pair_valid_q    <= pair_valid_d;
      word_q          <= word_d;
      cnt_q           <= cnt_d;
      slip_pend_q     <= slip_pend_d;
      dataout_q       <= dataout_d;
      dataout_valid_q <= dataout_valid_d;
    end
  end

  // Falling-edge beat capture.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      fall_q <= '0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign pair_h        = pair_h_q;
  assign pair_l        = pair_l_q;
  assign pair_valid    = pair_valid_q;
  assign dataout       = dataout_q;
  assign dataout_valid = dataout_valid_q;

endmodule

// File: tb/tb_iob_ddr_in.sv
// Bench for iob_ddr_in: three configurations share one stimulus stream and are
// checked every cycle against a beat-level model, plus literal directed checks.
module tb_iob_ddr_in;

  logic       clk = 1'b0;
  logic       rst, en, slip;
  logic [3:0] datain;

  logic [1:0]  ph0, pl0;
  logic [3:0]  ph1, pl1, ph2, pl2;
  logic        pv0, pv1, pv2, dv0, dv1, dv2;
  logic [7:0]  do0;
  logic [15:0] do1;
  logic [31:0] do2;

  iob_ddr_in #(.WIDTH(2), .BEATS(4)) u0 (
    .clk(clk), .rst(rst), .en(en), .slip(slip), .datain(datain[1:0]),
    .pair_h(ph0), .pair_l(pl0), .pair_valid(pv0), .dataout(do0), .dataout_valid(dv0));
  iob_ddr_in #(.WIDTH(4), .BEATS(4)) u1 (
    .clk(clk), .rst(rst), .en(en), .slip(slip), .datain(datain),
    .pair_h(ph1), .pair_l(pl1), .pair_valid(pv1), .dataout(do1), .dataout_valid(dv1));
  iob_ddr_in #(.WIDTH(4), .BEATS(8)) u2 (
    .clk(clk), .rst(rst), .en(en), .slip(slip), .datain(datain),
    .pair_h(ph2), .pair_l(pl2), .pair_valid(pv2), .dataout(do2), .dataout_valid(dv2));

  always #5 clk = ~clk;

  logic [3:0]  a_ph [3];
  logic [3:0]  a_pl [3];
  logic        a_pv [3];
  logic [31:0] a_do [3];
  logic        a_dv [3];
  always_comb begin
    a_ph[0] = {2'b00, ph0}; a_ph[1] = ph1; a_ph[2] = ph2;
    a_pl[0] = {2'b00, pl0}; a_pl[1] = pl1; a_pl[2] = pl2;
    a_pv[0] = pv0; a_pv[1] = pv1; a_pv[2] = pv2;
    a_do[0] = {24'd0, do0}; a_do[1] = {16'd0, do1}; a_do[2] = do2;
    a_dv[0] = dv0; a_dv[1] = dv1; a_dv[2] = dv2;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %h want %h", nm, inst, $time, act, exp);
    end
  endtask

  // Model: beats appended to a word in arrival order, word emitted when it holds BEATS beats.
  int unsigned wid [3];
  int unsigned bts [3];
  logic [31:0] m_acc [3];
  int          m_n   [3];
  bit          m_pend[3];
  logic [31:0] m_do  [3];
  bit          m_dv  [3];
  bit          m_pv, cap_en;
  logic [3:0]  m_ph, m_pl, cap_h, cap_l;

  function automatic logic [3:0] mk(input int i);
    return 4'((1 << wid[i]) - 1);
  endfunction

  task automatic push(input int i, input logic [3:0] b);
    m_acc[i] = m_acc[i] | (32'(b) << (m_n[i] * int'(wid[i])));
    m_n[i]++;
    if (m_n[i] == int'(bts[i])) begin
      m_do[i]  = m_acc[i];
      m_dv[i]  = 1'b1;
      m_acc[i] = '0;
      m_n[i]   = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_acc[i] = '0; m_n[i] = 0; m_pend[i] = 1'b0; m_do[i] = '0; m_dv[i] = 1'b0;
    end
    m_pv = 1'b0; m_ph = '0; m_pl = '0; cap_h = '0; cap_l = '0; cap_en = 1'b0;
  endtask

  bit tp_arm = 1'b0;
  int tp_cnt, tp_last, tp_bad;
  int cyc = 0;

  // Compare process: advance the model at each rising edge, check outputs just after it.
  initial begin
    logic s;
    bit drop;
    wid[0] = 2; wid[1] = 4; wid[2] = 4;
    bts[0] = 4; bts[1] = 4; bts[2] = 8;
    tp_cnt = 0; tp_last = -1; tp_bad = 0;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_reset();
      end else begin
        s = slip;
        for (int i = 0; i < 3; i++) begin
          m_dv[i] = 1'b0;
          if (m_pv) begin
            drop = m_pend[i] | s;
            m_pend[i] = 1'b0;
            if (!drop) push(i, m_ph & mk(i));
            push(i, m_pl & mk(i));
          end else if (s) begin
            m_pend[i] = 1'b1;
          end
        end
        m_pv = cap_en; m_ph = cap_h; m_pl = cap_l;
        cap_h = datain; cap_en = en;
      end
      #2;
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          chk("pair_h", i, 32'(a_ph[i]), 32'(m_ph & mk(i)));
          chk("pair_l", i, 32'(a_pl[i]), 32'(m_pl & mk(i)));
          chk("pair_valid", i, 32'(a_pv[i]), 32'(m_pv));
          chk("dataout", i, a_do[i], m_do[i]);
          chk("dataout_valid", i, 32'(a_dv[i]), 32'(m_dv[i]));
        end
      end
      if (!tp_arm) begin
        tp_cnt = 0; tp_last = -1; tp_bad = 0;
      end else if (dv2) begin
        if (tp_last >= 0 && cyc - tp_last != 4) tp_bad++;
        tp_last = cyc;
        tp_cnt++;
      end
      @(negedge clk);
      cap_l = rst ? 4'h0 : datain;
    end
  end

  // One clock cycle: h beat before the rising edge, l beat before the falling edge.
  task automatic drive(input logic [3:0] h, input logic [3:0] l, input logic e, input logic s);
    datain = h; en = e; slip = s;
    @(posedge clk); #1;
    datain = l; slip = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(4'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_pair_valid", i, 32'(a_pv[i]), 32'd0);
      chk("rst_dataout", i, a_do[i], 32'd0);
      chk("rst_dataout_valid", i, 32'(a_dv[i]), 32'd0);
      chk("rst_pair_h", i, 32'(a_ph[i]), 32'd0);
    end
    @(posedge clk); @(negedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; slip = 1'b0; datain = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    do_reset();

    // Basic packing.
    drive(4'h0, 4'h1, 1'b1, 1'b0);
    chk("basic_pv_e0", 0, 32'(pv0), 32'd0);
    drive(4'h2, 4'h3, 1'b1, 1'b0);
    chk("basic_pv_e1", 0, 32'(pv0), 32'd1);
    chk("basic_ph_e1", 0, 32'(ph0), 32'd0);
    chk("basic_pl_e1", 0, 32'(pl0), 32'd1);
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    chk("basic_pv_e2", 0, 32'(pv0), 32'd1);
    chk("basic_dv_e2", 0, 32'(dv0), 32'd0);
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    chk("basic_dv_e3", 0, 32'(dv0), 32'd1);
    chk("basic_do_e3", 0, 32'(do0), 32'hE4);
    chk("basic_do1_e3", 1, 32'(do1), 32'h3210);
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    chk("basic_dv_e4", 0, 32'(dv0), 32'd0);
    chk("basic_hold_e4", 0, 32'(do0), 32'hE4);

    // Gapped enable.
    do_reset();
    drive(4'h0, 4'h1, 1'b1, 1'b0);
    drive(4'h7, 4'h7, 1'b0, 1'b0);
    drive(4'h2, 4'h3, 1'b1, 1'b0);
    idle(3);
    chk("gap_do", 1, 32'(do1), 32'h3210);

    // Single slip ahead of the first pair.
    do_reset();
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    drive(4'h0, 4'h1, 1'b1, 1'b0);
    drive(4'h2, 4'h3, 1'b1, 1'b0);
    drive(4'h4, 4'h5, 1'b1, 1'b0);
    drive(4'h6, 4'h7, 1'b1, 1'b0);
    drive(4'h8, 4'h9, 1'b1, 1'b0);
    chk("slip_dv_w0", 1, 32'(dv1), 32'd1);
    chk("slip_do_w0", 1, 32'(do1), 32'h4321);
    idle(2);
    chk("slip_dv_w1", 1, 32'(dv1), 32'd1);
    chk("slip_do_w1", 1, 32'(do1), 32'h8765);

    // Two slip pulses while pairs are idle drop a single beat.
    do_reset();
    drive(4'h0, 4'h1, 1'b1, 1'b0);
    drive(4'h2, 4'h3, 1'b1, 1'b0);
    drive(4'h7, 4'h7, 1'b0, 1'b0);
    drive(4'h7, 4'h7, 1'b0, 1'b0);
    drive(4'h4, 4'h5, 1'b1, 1'b1);
    drive(4'h6, 4'h7, 1'b1, 1'b1);
    drive(4'h8, 4'h9, 1'b1, 1'b0);
    idle(2);
    chk("slip2_do", 1, 32'(do1), 32'h8765);
    chk("slip2_dv", 1, 32'(dv1), 32'd1);

    // Reset mid-word with a slip pending.
    do_reset();
    drive(4'h1, 4'h2, 1'b1, 1'b0);
    drive(4'h3, 4'h4, 1'b1, 1'b0);
    drive(4'h5, 4'h6, 1'b1, 1'b0);
    idle(2);
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    chk("pre_rst_do", 1, 32'(do1), 32'h4321);
    do_reset();
    drive(4'h9, 4'hA, 1'b1, 1'b0);
    drive(4'hB, 4'hC, 1'b1, 1'b0);
    idle(2);
    chk("post_rst_dv", 1, 32'(dv1), 32'd1);
    chk("post_rst_do", 1, 32'(do1), 32'hCBA9);

    // Throughput on the 8-beat instance.
    do_reset();
    tp_arm = 1'b1;
    for (int k = 0; k < 64; k++) drive(4'(2 * k), 4'(2 * k + 1), 1'b1, 1'b0);
    idle(3);
    chk("tp_words", 2, 32'(tp_cnt), 32'd16);
    chk("tp_gaps", 2, 32'(tp_bad), 32'd0);
    tp_arm = 1'b0;

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        drive(4'($urandom), 4'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
